// File: rtl/noc_router_lookup_mc_reg_pkg.sv
// Shared types and arithmetic route functions for the mesh NoC route-lookup stage.
// Direction indices L=0 N=1 E=2 S=3 W=4 match the bit order of every route vector.
package noc_router_lookup_mc_reg_pkg;

    typedef enum logic [2:0] {
        DIR_L = 3'd0,
        DIR_N = 3'd1,
        DIR_E = 3'd2,
        DIR_S = 3'd3,
        DIR_W = 3'd4
    } dir_e;

    typedef enum logic [1:0] {
        WORM_IDLE,
        WORM_ROUTE,
        WORM_DROP
    } worm_e;

    localparam int NUM_DIRS = 5;

    // Header layout: {dy,dx} at bit 0, then north, east, south, west bounds.
    function automatic int field_lsb(input dir_e d, input int xb, input int yb);
        case (d)
            DIR_N:   return xb + yb;
            DIR_E:   return xb + 2 * yb;
            DIR_S:   return 2 * xb + 2 * yb;
            DIR_W:   return 2 * xb + 3 * yb;
            default: return 0;
        endcase
    endfunction

    function automatic logic [4:0] xy_route(input int x, input int y, input int dx, input int dy);
        logic [4:0] r;
        r = '0;
        if (dx > x)      r[DIR_E] = 1'b1;
        else if (dx < x) r[DIR_W] = 1'b1;
        else if (dy > y) r[DIR_N] = 1'b1;
        else             r[DIR_S] = 1'b1;
        return r;
    endfunction

    // Phase 0 fans out from the centre node; phase 1 spreads column-first inside the box.
    function automatic logic [4:0] mc_route(input logic phase, input int x, input int y,
                                            input int dx, input int dy,
                                            input int n_id, input int e_id,
                                            input int s_id, input int w_id,
                                            input logic mask_self);
        logic [4:0] r;
        r = '0;
        if (!phase) begin
            r[DIR_L] = 1'b1;
            r[DIR_N] = (y != n_id);
            r[DIR_S] = (y != s_id);
            r[DIR_E] = (x != e_id);
            r[DIR_W] = (x != w_id);
        end else begin
            r[DIR_L] = mask_self;
            if (y != dy) begin
                if (y > dy && y < n_id)      r[DIR_N] = 1'b1;
                else if (y < dy && y > s_id) r[DIR_S] = 1'b1;
            end else begin
                r[DIR_N] = (y != n_id);
                r[DIR_S] = (y != s_id);
                r[DIR_E] = (x > dx && x < e_id);
                r[DIR_W] = (x < dx && x > w_id);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/noc_router_lookup_mc_reg_if.sv
// Flit-side bundle of the route-lookup stage: input FIFO side plus the five output arbiters.
interface noc_router_lookup_mc_reg_if #(
    parameter int FLIT_WIDTH = 256
);
    logic [FLIT_WIDTH-1:0] in_flit;
    logic                  in_last;
    logic                  in_valid;
    logic                  in_ready;
    logic [FLIT_WIDTH-1:0] out_flit;
    logic                  out_last;
    logic [4:0]            out_valid;
    logic [4:0]            out_ready;
    logic                  err_noroute;

    modport master (
        output in_flit, in_last, in_valid, out_ready,
        input  in_ready, out_flit, out_last, out_valid, err_noroute
    );

    modport slave (
        input  in_flit, in_last, in_valid, out_ready,
        output in_ready, out_flit, out_last, out_valid, err_noroute
    );
endinterface

// File: rtl/noc_router_lookup_mc_reg_fork.sv
// One-entry eager-fork register: presents one word to every selected output and
// tracks which outputs already took it, so each output sees the word exactly once.
module noc_router_lookup_mc_reg_fork #(
    parameter int W = 8,
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_load,
    input  logic [W-1:0] in_data,
    input  logic [N-1:0] in_route,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic [N-1:0] out_valid,
    input  logic [N-1:0] out_ready
);
    logic         full;
    logic [N-1:0] route;
    logic [N-1:0] served;
    logic [N-1:0] fire;
    logic         done;

    assign out_valid = {N{full}} & route & ~served;
    assign fire      = out_valid & out_ready;
    assign done      = full && ((served | fire) == route);
    assign in_ready  = ~full | done;

    // A load wins over done so back-to-back words keep one per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 1'b0;
            route    <= '0;
            served   <= '0;
            out_data <= '0;
        end else if (in_load) begin
            full     <= 1'b1;
            route    <= in_route;
            served   <= '0;
            out_data <= in_data;
        end else if (done) begin
            full   <= 1'b0;
            served <= '0;
        end else begin
            served <= served | fire;
        end
    end
endmodule

// File: rtl/noc_router_lookup_mc_reg.sv
// Route-lookup stage of a mesh NoC input port: arithmetic XY / bounding-box multicast
// routing, wormhole route hold, drop of unroutable packets and an eager-fork output register.
module noc_router_lookup_mc_reg
    import noc_router_lookup_mc_reg_pkg::*;
#(
    parameter int FLIT_WIDTH = 256,
    parameter int X_BITS     = 2,
    parameter int Y_BITS     = 2,
    parameter int X          = 0,
    parameter int Y          = 0,
    parameter int MASK_LSB   = 160
) (
    input  logic clk,
    input  logic rst_n,
    noc_router_lookup_mc_reg_if.slave bus
);
    localparam int N_LSB    = field_lsb(DIR_N, X_BITS, Y_BITS);
    localparam int E_LSB    = field_lsb(DIR_E, X_BITS, Y_BITS);
    localparam int S_LSB    = field_lsb(DIR_S, X_BITS, Y_BITS);
    localparam int W_LSB    = field_lsb(DIR_W, X_BITS, Y_BITS);
    localparam int SELF_IDX = (Y << X_BITS) + X;

    logic [X_BITS-1:0] dx, e_id, w_id;
    logic [Y_BITS-1:0] dy, n_id, s_id;
    logic              phase, central, mask_self;
    logic [4:0]        hdr_route, fork_route;
    logic [FLIT_WIDTH-1:0] flit_rewr;

    worm_e      state, state_next;
    logic [4:0] worm_route;
    logic       accept, fork_load, fork_in_ready, load_worm, err_next;

    assign dx        = bus.in_flit[X_BITS-1:0];
    assign dy        = bus.in_flit[X_BITS +: Y_BITS];
    assign n_id      = bus.in_flit[N_LSB +: Y_BITS];
    assign e_id      = bus.in_flit[E_LSB +: X_BITS];
    assign s_id      = bus.in_flit[S_LSB +: Y_BITS];
    assign w_id      = bus.in_flit[W_LSB +: X_BITS];
    assign phase     = bus.in_flit[FLIT_WIDTH-1];
    assign mask_self = bus.in_flit[MASK_LSB + SELF_IDX];
    assign central   = ~phase && (int'(dx) == X) && (int'(dy) == Y);

    assign hdr_route = (phase || central)
        ? mc_route(phase, X, Y, int'(dx), int'(dy), int'(n_id), int'(e_id),
                   int'(s_id), int'(w_id), mask_self)
        : xy_route(X, Y, int'(dx), int'(dy));

    // The centre node turns the packet around into the spread phase.
    assign flit_rewr = (central && state == WORM_IDLE)
        ? {1'b1, bus.in_flit[FLIT_WIDTH-2:0]} : bus.in_flit;

    assign accept       = bus.in_valid & fork_in_ready;
    assign bus.in_ready = fork_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= WORM_IDLE;
            worm_route      <= '0;
            bus.err_noroute <= 1'b0;
        end else begin
            state           <= state_next;
            bus.err_noroute <= err_next;
            if (load_worm) worm_route <= hdr_route;
        end
    end

    always_comb begin
        state_next = state;
        if (accept) begin
            case (state)
                WORM_IDLE: begin
                    if (!bus.in_last) state_next = (hdr_route != '0) ? WORM_ROUTE : WORM_DROP;
                end
                WORM_ROUTE, WORM_DROP: begin
                    if (bus.in_last) state_next = WORM_IDLE;
                end
                default: state_next = WORM_IDLE;
            endcase
        end
    end

    always_comb begin
        fork_route = (state == WORM_IDLE) ? hdr_route : worm_route;
        fork_load  = accept && (((state == WORM_IDLE) && hdr_route != '0) || state == WORM_ROUTE);
        load_worm  = accept && (state == WORM_IDLE) && !bus.in_last && hdr_route != '0;
        err_next   = accept && (state == WORM_IDLE) && hdr_route == '0;
    end

    noc_router_lookup_mc_reg_fork #(
        .W (FLIT_WIDTH + 1),
        .N (NUM_DIRS)
    ) u_fork (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_load   (fork_load),
        .in_data   ({bus.in_last, flit_rewr}),
        .in_route  (fork_route),
        .in_ready  (fork_in_ready),
        .out_data  ({bus.out_last, bus.out_flit}),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready)
    );
endmodule

// File: tb/tb_noc_router_lookup_mc_reg.sv
// Directed bench for the route-lookup stage at node (1,1) of a 4x4 mesh.
module tb_noc_router_lookup_mc_reg;
    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    noc_router_lookup_mc_reg_if #(.FLIT_WIDTH(256)) bus ();

    noc_router_lookup_mc_reg #(
        .FLIT_WIDTH (256),
        .X_BITS     (2),
        .Y_BITS     (2),
        .X          (1),
        .Y          (1),
        .MASK_LSB   (160)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] make_hdr(input logic phase, input logic [1:0] dx,
                                              input logic [1:0] dy, input logic [1:0] n,
                                              input logic [1:0] e, input logic [1:0] s,
                                              input logic [1:0] w, input logic [15:0] mask,
                                              input logic [15:0] tag);
        logic [255:0] f;
        f = '0;
        f[1:0]     = dx;
        f[3:2]     = dy;
        f[5:4]     = n;
        f[7:6]     = e;
        f[9:8]     = s;
        f[11:10]   = w;
        f[115:100] = tag;
        f[175:160] = mask;
        f[255]     = phase;
        return f;
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] actual,
                               input logic [255:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [255:0] flit, input logic last,
                                 input logic valid, input logic [4:0] ready);
        bus.in_flit   = flit;
        bus.in_last   = last;
        bus.in_valid  = valid;
        bus.out_ready = ready;
        #1;
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    logic [255:0] hdr1, body_a, body_b, hdr2, exp2, hdr3, hdr4a, hdr4b, hdr5, body5;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        hdr1   = make_hdr(1'b0, 2'd3, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 16'h0000, 16'h0101);
        body_a = 256'hAAA0;
        body_b = 256'h5550;
        hdr2   = make_hdr(1'b0, 2'd1, 2'd1, 2'd3, 2'd2, 2'd0, 2'd1, 16'h0000, 16'h0202);
        exp2   = hdr2 | (256'd1 << 255);
        hdr3   = make_hdr(1'b0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 16'h0000, 16'h0303);
        hdr4a  = make_hdr(1'b1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 16'h0020, 16'h0404);
        hdr4b  = make_hdr(1'b1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 16'h0000, 16'h0405);
        hdr5   = make_hdr(1'b1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd1, 2'd0, 16'h0000, 16'h0505);
        body5  = make_hdr(1'b0, 2'd3, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 16'h0000, 16'h0506);

        rst_n = 1'b0;
        applyStimulus('0, 1'b0, 1'b0, 5'b11111);
        checkOutput("rst_valid", 256'(bus.out_valid), 256'h0);
        checkOutput("rst_flit", bus.out_flit, 256'h0);
        checkOutput("rst_last", 256'(bus.out_last), 256'h0);
        checkOutput("rst_err", 256'(bus.err_noroute), 256'h0);
        checkOutput("rst_ready", 256'(bus.in_ready), 256'h1);
        step_clk();
        step_clk();
        rst_n = 1'b1;
        step_clk();

        // Unicast 3-flit worm heading east
        applyStimulus(hdr1, 1'b0, 1'b1, 5'b11111);
        checkOutput("t1_rdy", 256'(bus.in_ready), 256'h1);
        step_clk();
        checkOutput("t1_v0", 256'(bus.out_valid), 256'h04);
        checkOutput("t1_f0", bus.out_flit, hdr1);
        applyStimulus(body_a, 1'b0, 1'b1, 5'b11111);
        step_clk();
        checkOutput("t1_v1", 256'(bus.out_valid), 256'h04);
        checkOutput("t1_f1", bus.out_flit, body_a);
        applyStimulus(body_b, 1'b1, 1'b1, 5'b11111);
        step_clk();
        checkOutput("t1_v2", 256'(bus.out_valid), 256'h04);
        checkOutput("t1_f2", bus.out_flit, body_b);
        checkOutput("t1_l2", 256'(bus.out_last), 256'h1);
        applyStimulus('0, 1'b0, 1'b0, 5'b11111);
        step_clk();
        checkOutput("t1_idle", 256'(bus.out_valid), 256'h0);

        // Central node single flit, phase bit rewritten
        applyStimulus(hdr2, 1'b1, 1'b1, 5'b11111);
        step_clk();
        checkOutput("t2_valid", 256'(bus.out_valid), 256'h0F);
        checkOutput("t2_flit", bus.out_flit, exp2);
        checkOutput("t2_last", 256'(bus.out_last), 256'h1);
        applyStimulus('0, 1'b0, 1'b0, 5'b11111);
        step_clk();
        checkOutput("t2_idle", 256'(bus.out_valid), 256'h0);

        // Eager fork with E stalled for three cycles
        applyStimulus(hdr2, 1'b1, 1'b1, 5'b11011);
        step_clk();
        checkOutput("t3_v0", 256'(bus.out_valid), 256'h0F);
        applyStimulus(hdr3, 1'b1, 1'b1, 5'b11011);
        checkOutput("t3_r0", 256'(bus.in_ready), 256'h0);
        step_clk();
        checkOutput("t3_v1", 256'(bus.out_valid), 256'h04);
        checkOutput("t3_r1", 256'(bus.in_ready), 256'h0);
        step_clk();
        checkOutput("t3_v2", 256'(bus.out_valid), 256'h04);
        checkOutput("t3_r2", 256'(bus.in_ready), 256'h0);
        step_clk();
        applyStimulus(hdr3, 1'b1, 1'b1, 5'b11111);
        checkOutput("t3_v3", 256'(bus.out_valid), 256'h04);
        checkOutput("t3_r3", 256'(bus.in_ready), 256'h1);
        checkOutput("t3_hold", bus.out_flit, exp2);
        step_clk();
        checkOutput("t3_next_v", 256'(bus.out_valid), 256'h10);
        checkOutput("t3_next_f", bus.out_flit, hdr3);
        applyStimulus('0, 1'b0, 1'b0, 5'b11111);
        step_clk();
        checkOutput("t3_idle", 256'(bus.out_valid), 256'h0);

        // Phase 1 spread, mask bit 5 set then clear, back to back
        applyStimulus(hdr4a, 1'b1, 1'b1, 5'b11111);
        step_clk();
        checkOutput("t4_set", 256'(bus.out_valid), 256'h09);
        checkOutput("t4_flit", bus.out_flit, hdr4a);
        applyStimulus(hdr4b, 1'b1, 1'b1, 5'b11111);
        checkOutput("t4_rdy", 256'(bus.in_ready), 256'h1);
        step_clk();
        checkOutput("t4_clr", 256'(bus.out_valid), 256'h08);
        applyStimulus('0, 1'b0, 1'b0, 5'b11111);
        step_clk();
        checkOutput("t4_idle", 256'(bus.out_valid), 256'h0);

        // Empty route: whole 4-flit packet dropped, single error pulse
        applyStimulus(hdr5, 1'b0, 1'b1, 5'b11111);
        checkOutput("t5_rdy_h", 256'(bus.in_ready), 256'h1);
        step_clk();
        checkOutput("t5_err_h", 256'(bus.err_noroute), 256'h1);
        checkOutput("t5_valid_h", 256'(bus.out_valid), 256'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(body5, (i == 2), 1'b1, 5'b11111);
            checkOutput("t5_rdy_b", 256'(bus.in_ready), 256'h1);
            step_clk();
            checkOutput("t5_err_b", 256'(bus.err_noroute), 256'h0);
            checkOutput("t5_valid_b", 256'(bus.out_valid), 256'h0);
        end
        applyStimulus(hdr1, 1'b1, 1'b1, 5'b11111);
        step_clk();
        checkOutput("t5_next_v", 256'(bus.out_valid), 256'h04);
        checkOutput("t5_next_err", 256'(bus.err_noroute), 256'h0);
        applyStimulus('0, 1'b0, 1'b0, 5'b11111);
        step_clk();

        // Asynchronous reset mid-worm with the register full
        applyStimulus(hdr1, 1'b0, 1'b1, 5'b11111);
        step_clk();
        checkOutput("t6_v0", 256'(bus.out_valid), 256'h04);
        applyStimulus(body_a, 1'b0, 1'b0, 5'b00000);
        step_clk();
        checkOutput("t6_held", 256'(bus.out_valid), 256'h04);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_v", 256'(bus.out_valid), 256'h0);
        checkOutput("t6_rst_f", bus.out_flit, 256'h0);
        checkOutput("t6_rst_err", 256'(bus.err_noroute), 256'h0);
        step_clk();
        rst_n = 1'b1;
        applyStimulus(hdr2, 1'b1, 1'b1, 5'b11111);
        step_clk();
        checkOutput("t6_new_v", 256'(bus.out_valid), 256'h0F);
        checkOutput("t6_new_f", bus.out_flit, exp2);
        applyStimulus('0, 1'b0, 1'b0, 5'b11111);
        step_clk();
        checkOutput("t6_idle", 256'(bus.out_valid), 256'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
